// File: rtl/ofs_fim_pcie_ss_sb2ib.sv
// Side-band to in-band header converter: re-inserts the SOP header into tdata, shifting payload by H bytes.
// Optional payload length checker enabled by `define OFS_FIM_PCIE_SS_SB2IB_LEN_CHECK_EN.
module ofs_fim_pcie_ss_sb2ib #(
  parameter int DATA_WIDTH = 512,
  parameter int HDR_WIDTH  = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_tvalid,
  output logic                      in_tready,
  input  logic [DATA_WIDTH-1:0]     in_tdata,
  input  logic [DATA_WIDTH/8-1:0]   in_tkeep,
  input  logic                      in_tlast,
  input  logic [HDR_WIDTH:0]        in_tuser_vendor,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic [DATA_WIDTH-1:0]     out_tdata,
  output logic [DATA_WIDTH/8-1:0]   out_tkeep,
  output logic                      out_tlast,
  output logic                      out_tuser_vendor,
  output logic                      err_len
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int H  = HDR_WIDTH / 8;
  localparam int L  = KW - H;

  typedef enum logic [1:0] {
    ST_SOP   = 2'd0,
    ST_MID   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                r_state;
  logic [HDR_WIDTH-1:0]  r_carry_data;
  logic [H-1:0]          r_carry_keep;

  logic                  w_free;
  logic                  w_acc;
  logic [HDR_WIDTH-1:0]  w_low_data;
  logic [H-1:0]          w_low_keep;
  logic [HDR_WIDTH-1:0]  w_next_carry_data;
  logic [H-1:0]          w_next_carry_keep;

  // Handshake: a beat moves on a port when valid && ready at a rising clk; valid never waits on ready,
  // and the output beat is held unchanged until taken.
  assign w_free     = !out_tvalid || out_tready;
  assign in_tready  = w_free && (r_state != ST_FLUSH);
  assign w_acc      = in_tvalid && in_tready;

  // The low H bytes of an output beat come from the header on SOP, else from the previous beat's tail.
  assign w_low_data        = (r_state == ST_SOP) ? in_tuser_vendor[HDR_WIDTH:1] : r_carry_data;
  assign w_low_keep        = (r_state == ST_SOP) ? {H{1'b1}} : r_carry_keep;
  assign w_next_carry_data = in_tdata[DATA_WIDTH-1 -: HDR_WIDTH];
  assign w_next_carry_keep = in_tkeep[KW-1 -: H];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_SOP;
      r_carry_data     <= '0;
      r_carry_keep     <= '0;
      out_tvalid       <= 1'b0;
      out_tdata        <= '0;
      out_tkeep        <= '0;
      out_tlast        <= 1'b0;
      out_tuser_vendor <= 1'b0;
    end else begin
      if (out_tvalid && out_tready) begin
        out_tvalid <= 1'b0;
      end
      case (r_state)
        ST_SOP, ST_MID: begin
          if (w_acc) begin
            out_tvalid   <= 1'b1;
            out_tdata    <= {in_tdata[L*8-1:0], w_low_data};
            out_tkeep    <= {in_tkeep[L-1:0], w_low_keep};
            if (r_state == ST_SOP) begin
              out_tuser_vendor <= in_tuser_vendor[0];
            end
            r_carry_data <= w_next_carry_data;
            r_carry_keep <= w_next_carry_keep;
            if (in_tlast && (w_next_carry_keep == '0)) begin
              out_tlast <= 1'b1;
              r_state   <= ST_SOP;
            end else if (in_tlast) begin
              out_tlast <= 1'b0;
              r_state   <= ST_FLUSH;
            end else begin
              out_tlast <= 1'b0;
              r_state   <= ST_MID;
            end
          end
        end
        ST_FLUSH: begin
          if (w_free) begin
            out_tvalid   <= 1'b1;
            out_tdata    <= {{(L*8){1'b0}}, r_carry_data};
            out_tkeep    <= {{L{1'b0}}, r_carry_keep};
            out_tlast    <= 1'b1;
            r_carry_keep <= '0;
            r_state      <= ST_SOP;
          end
        end
        default: r_state <= ST_SOP;
      endcase
    end
  end

`ifdef OFS_FIM_PCIE_SS_SB2IB_LEN_CHECK_EN
  localparam int CW = 20;

  logic [HDR_WIDTH-1:0] w_hdr;
  logic                 w_sop;
  logic [CW-1:0]        w_beat_bytes;
  logic [10:0]          w_hdr_dw;
  logic                 w_dp;
  logic [10:0]          w_exp_dw;
  logic [CW-1:0]        w_total_bytes;
  logic                 r_dp;
  logic [10:0]          r_exp_dw;
  logic [CW-1:0]        r_bytes;

  assign w_hdr = in_tuser_vendor[HDR_WIDTH:1];
  assign w_sop = (r_state == ST_SOP);

  always_comb begin
    w_beat_bytes = '0;
    for (int i = 0; i < KW; i++) begin
      w_beat_bytes = w_beat_bytes + CW'(in_tkeep[i]);
    end
  end

  // A zero length field encodes the maximum of 1024 DW.
  assign w_hdr_dw      = ({w_hdr[17:16], w_hdr[31:24]} == 10'd0) ? 11'd1024
                                                                 : {1'b0, w_hdr[17:16], w_hdr[31:24]};
  assign w_dp          = w_sop ? w_hdr[6]  : r_dp;
  assign w_exp_dw      = w_sop ? w_hdr_dw  : r_exp_dw;
  assign w_total_bytes = (w_sop ? '0 : r_bytes) + w_beat_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp     <= 1'b0;
      r_exp_dw <= '0;
      r_bytes  <= '0;
      err_len  <= 1'b0;
    end else if (w_acc) begin
      r_dp     <= w_dp;
      r_exp_dw <= w_exp_dw;
      r_bytes  <= w_total_bytes;
      if (in_tlast && w_dp && (w_total_bytes[CW-1:2] != (CW-2)'(w_exp_dw))) begin
        err_len <= 1'b1;
      end
    end
  end
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_sb2ib.sv
// Bench for ofs_fim_pcie_ss_sb2ib: directed cases, mid-TLP reset and random TLPs against a byte-stream model.
// The model treats each TLP as header bytes followed by payload bytes, re-chunked into full-width beats.
module tb_ofs_fim_pcie_ss_sb2ib;

  localparam int DW = 512;
  localparam int HW = 256;
  localparam int KW = DW / 8;
  localparam int EW = DW + KW + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_tvalid = 1'b0;
  logic           in_tready;
  logic [DW-1:0]  in_tdata = '0;
  logic [KW-1:0]  in_tkeep = '0;
  logic           in_tlast = 1'b0;
  logic [HW:0]    in_tuser_vendor = '0;
  logic           out_tvalid;
  logic           out_tready = 1'b1;
  logic [DW-1:0]  out_tdata;
  logic [KW-1:0]  out_tkeep;
  logic           out_tlast;
  logic           out_tuser_vendor;
  logic           err_len;

  logic [EW-1:0]  exp_q[$];
  int             n_checks = 0;
  int             n_fail = 0;
  bit             mon_en = 1'b0;
  bit             rand_rdy = 1'b0;
  bit             rand_gap = 1'b0;
  logic           exp_err;

  ofs_fim_pcie_ss_sb2ib #(.DATA_WIDTH(DW), .HDR_WIDTH(HW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_tvalid        (in_tvalid),
    .in_tready        (in_tready),
    .in_tdata         (in_tdata),
    .in_tkeep         (in_tkeep),
    .in_tlast         (in_tlast),
    .in_tuser_vendor  (in_tuser_vendor),
    .out_tvalid       (out_tvalid),
    .out_tready       (out_tready),
    .out_tdata        (out_tdata),
    .out_tkeep        (out_tkeep),
    .out_tlast        (out_tlast),
    .out_tuser_vendor (out_tuser_vendor),
    .err_len          (err_len)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] kmask(input logic [KW-1:0] k);
    logic [DW-1:0] m;
    for (int i = 0; i < KW; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [DW-1:0] rand_bits();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [HW-1:0] make_hdr(input logic dp, input int dw);
    logic [DW-1:0] r;
    logic [HW-1:0] h;
    logic [9:0]    len;
    r   = rand_bits();
    h   = r[HW-1:0];
    len = 10'(dw);
    h[6] = dp;
    if (dp) begin
      h[17:16] = len[9:8];
      h[31:24] = len[7:0];
    end
    return h;
  endfunction

  // Sink ready: random stalls of about one cycle in sixteen when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_tready = rand_rdy ? ($urandom_range(0, 15) != 0) : 1'b1;
    end
  end

  // Scoreboard and stall-stability monitor
  logic [EW-1:0] mon_e;
  logic [EW-1:0] held;
  bit            stalled = 1'b0;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", EW'(out_tvalid), EW'(1'b1));
        check("stall_stable", {out_tuser_vendor, out_tlast, out_tkeep, out_tdata}, held);
      end
      if (out_tvalid && out_tready) begin
        stalled = 1'b0;
        check("exp_q_nonempty", EW'(exp_q.size() != 0), EW'(1'b1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_tkeep", EW'(out_tkeep), EW'(mon_e[DW +: KW]));
          check("out_tlast", EW'(out_tlast), EW'(mon_e[DW+KW]));
          check("out_vendor", EW'(out_tuser_vendor), EW'(mon_e[DW+KW+1]));
          check("out_tdata", EW'(out_tdata & kmask(mon_e[DW +: KW])),
                EW'(mon_e[DW-1:0] & kmask(mon_e[DW +: KW])));
        end
      end else if (out_tvalid) begin
        stalled = 1'b1;
        held    = {out_tuser_vendor, out_tlast, out_tkeep, out_tdata};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [HW:0] u);
    int t;
    t = 0;
    if (rand_gap && ($urandom_range(0, 7) == 0)) begin
      in_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_tvalid       = 1'b1;
    in_tdata        = d;
    in_tkeep        = k;
    in_tlast        = l;
    in_tuser_vendor = u;
    @(negedge clk);
    while (!in_tready && t < 200) begin
      t++;
      @(negedge clk);
    end
    check("in_tready_within_bound", EW'(in_tready), EW'(1'b1));
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
  endtask

  task automatic send_tlp(input logic [HW-1:0] hdr, input logic vend, input int nbytes);
    logic [7:0]    pl[$];
    logic [7:0]    s[$];
    logic [DW-1:0] d;
    logic [DW-1:0] junk;
    logic [KW-1:0] k;
    logic [HW:0]   u;
    int            nb;
    for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom));
    for (int i = 0; i < HW/8; i++) s.push_back(hdr[8*i +: 8]);
    for (int i = 0; i < nbytes; i++) s.push_back(pl[i]);
    for (int b = 0; b * KW < s.size(); b++) begin
      d = '0;
      k = '0;
      for (int j = 0; j < KW; j++) begin
        if (b * KW + j < s.size()) begin
          d[8*j +: 8] = s[b*KW + j];
          k[j] = 1'b1;
        end
      end
      exp_q.push_back({vend, ((b + 1) * KW >= s.size()), k, d});
    end
    nb = (nbytes == 0) ? 1 : (nbytes + KW - 1) / KW;
    for (int b = 0; b < nb; b++) begin
      d = rand_bits();
      k = '0;
      for (int j = 0; j < KW; j++) begin
        if (b * KW + j < nbytes) begin
          d[8*j +: 8] = pl[b*KW + j];
          k[j] = 1'b1;
        end
      end
      junk = rand_bits();
      u = (b == 0) ? {hdr, vend} : {junk[HW-1:0], 1'($urandom)};
      send_beat(d, k, (b == nb - 1), u);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", EW'(exp_q.size()), EW'(0));
  endtask

  // Main sequence
  initial begin
    int dw;
`ifdef OFS_FIM_PCIE_SS_SB2IB_LEN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_tvalid", EW'(out_tvalid), EW'(1'b0));
    check("rst_out_tkeep", EW'(out_tkeep), EW'(0));
    check("rst_out_tlast", EW'(out_tlast), EW'(1'b0));
    check("rst_err_len", EW'(err_len), EW'(1'b0));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    #1;
    check("idle_in_tready", EW'(in_tready), EW'(1'b1));

    // Header-only MRd, 8 DW MWr, then 16 DW MWr that needs a flush beat
    send_tlp(256'h20, 1'b0, 0);
    send_tlp(make_hdr(1'b1, 8), 1'b1, 32);
    send_tlp(make_hdr(1'b1, 16), 1'b0, 64);
    check("flush_in_tready", EW'(in_tready), EW'(1'b0));
    wait_drain();

    // Reset while beat 2 of a 3-beat TLP is presented
    mon_en = 1'b0;
    send_beat(rand_bits(), {KW{1'b1}}, 1'b0, {make_hdr(1'b1, 40), 1'b1});
    in_tvalid = 1'b1;
    in_tdata  = rand_bits();
    in_tkeep  = {KW{1'b1}};
    in_tlast  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midtlp_rst_out_tvalid", EW'(out_tvalid), EW'(1'b0));
    check("midtlp_rst_out_tkeep", EW'(out_tkeep), EW'(0));
    in_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    send_tlp(make_hdr(1'b1, 12), 1'b1, 48);
    wait_drain();

    // Random TLPs with random sink stalls and source gaps
    rand_rdy = 1'b1;
    rand_gap = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      dw = $urandom_range(0, 32);
      if ($urandom_range(0, 9) == 0) dw = 0;
      send_tlp(make_hdr(dw != 0, dw), 1'($urandom), dw * 4);
    end
    wait_drain();
    check("err_len_clean", EW'(err_len), EW'(1'b0));

    // Length mismatch: header says 4 DW, 8 DW of keep sent
    rand_rdy = 1'b0;
    rand_gap = 1'b0;
    send_tlp(make_hdr(1'b1, 4), 1'b0, 32);
    wait_drain();
    check("err_len_set", EW'(err_len), EW'(exp_err));
    send_tlp(make_hdr(1'b1, 8), 1'b1, 32);
    wait_drain();
    check("err_len_sticky", EW'(err_len), EW'(exp_err));
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("err_len_rst", EW'(err_len), EW'(1'b0));
    check("final_exp_q_empty", EW'(exp_q.size()), EW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofs_fim_pcie_ss_sb2ib.md
Name: ofs_fim_pcie_ss_sb2ib

Overview:
Converts a PCIe SS AXI-S stream with side-band headers back to in-band headers, one TLP per SOP.
- Input: header carried in tuser_vendor[HDR_WIDTH:1] on the SOP beat; payload starts at tdata bit 0.
- Output: header occupies tdata[HDR_WIDTH-1:0] of the SOP beat; payload follows immediately.
- Sits directly downstream of the in-band-to-side-band stage, for paths (e.g. TX to the hard IP) that require in-band format.

Parameters:
- DATA_WIDTH, 512, tdata width in bits; must be ≥ 2*HDR_WIDTH and a multiple of HDR_WIDTH.
- HDR_WIDTH, 256, side-band header width in bits; fixed PCIe SS header size.

Ports:
- clk, input, 1, sole clock.
- rst, input, 1, asynchronous active-high reset.
- in_tvalid, input, 1, source beat valid.
- in_tready, output, 1, DUT accepts beat.
- in_tdata, input, DATA_WIDTH, payload, left-aligned at bit 0.
- in_tkeep, input, DATA_WIDTH/8, byte enables, contiguous from byte 0.
- in_tlast, input, 1, last beat of TLP.
- in_tuser_vendor, input, 1+HDR_WIDTH, bit0 = vendor flag; [HDR_WIDTH:1] = header, valid on SOP beat only.
- out_tvalid, output, 1, output beat valid.
- out_tready, input, 1, sink ready.
- out_tdata, output, DATA_WIDTH, in-band beat.
- out_tkeep, output, DATA_WIDTH/8, byte enables.
- out_tlast, output, 1, last beat.
- out_tuser_vendor, output, 1, vendor flag of the current TLP.
- err_len, output, 1, sticky length mismatch; only present with the optional feature, otherwise tied 0.

Behaviour:
- Reset: asynchronous and active-high.
  - out_tvalid=0, out_tlast=0, out_tkeep=0, err_len=0.
  - State=SOP, carry register cleared.
  - out_tdata and out_tuser_vendor are don't-care.
- Output register: a single output register; latency from input accept to output valid is 1 cycle.
- Ready: in_tready = (!out_tvalid || out_tready) && state != FLUSH. A beat is accepted when in_tvalid && in_tready.
- Split point: H = HDR_WIDTH/8 bytes; L = DATA_WIDTH/8 − H.
- Carry register: holds the upper H bytes of the last accepted input beat, together with their keep bits.
- State SOP (next input beat is a TLP start), on accept:
  - out_tdata = {in_tdata[L*8-1:0], hdr}.
  - out_tkeep = {in_tkeep[L-1:0], H ones}.
  - out_tuser_vendor = in_tuser_vendor[0]; the flag is latched for the whole TLP.
  - Carry ← upper H bytes of data and keep.
  - If in_tlast and carry keep == 0: out_tlast=1, stay in SOP.
  - If in_tlast and carry keep != 0: out_tlast=0, go to FLUSH.
  - If !in_tlast: go to MID.
- State MID, on accept:
  - out_tdata = {in_tdata[L*8-1:0], carry}; out_tkeep = {in_tkeep[L-1:0], carry_keep}.
  - Update carry.
  - Last-beat and FLUSH decision is the same as in SOP; when the TLP ends on this beat, return to SOP.
- State FLUSH: no input accepted. When the output register is free:
  - Emit {zeros, carry} with keep {L zeros, carry_keep} and out_tlast=1.
  - Go to SOP.
- Header-only TLP (SOP && tlast && in_tkeep==0): one output beat, keep = H ones, tlast=1.
- Timing:
  - Back-to-back TLPs need no idle cycle unless FLUSH is required.
  - FLUSH costs exactly 1 extra output beat.
- out_tvalid is held with data stable until out_tready is asserted.
- in_tuser_vendor[HDR_WIDTH:1] is ignored on non-SOP beats.
- Reset asserted mid-TLP discards the carry and any partial packet; the first beat after reset is treated as SOP.

Optional Feature:
- Macro: OFS_FIM_PCIE_SS_SB2IB_LEN_CHECK_EN.
- When the macro is defined, the block checks payload length on TLPs whose header has hdr[6] (data present) set:
  - Expected DW count = {hdr[17:16], hdr[31:24]}, where 0 means 1024.
  - Actual count = accumulated popcount(in_tkeep)/4 over the TLP.
  - On the tlast accept, a mismatch sets err_len sticky; it is cleared only by rst.
  - Output data is unaffected by a mismatch.
- When the macro is undefined, the checker logic is absent and err_len is tied to 0.

Test Plan:
- Header-only MRd, hdr=0x…00000020, tkeep=0, tlast=1 → one out beat, tdata[255:0]=hdr, tkeep=64'h0000_0000_FFFF_FFFF, tlast=1, no FLUSH.
- MWr, 8 DW, SOP beat tkeep=32'hFFFFFFFF in bits [31:0] → one out beat, tkeep all-ones, tlast=1; out_tdata[511:256]=in_tdata[255:0].
- MWr, 16 DW, single input beat with full keep → two out beats:
  - beat 1: tkeep all-ones, tlast=0.
  - beat 2: tdata[255:0]=in_tdata[511:256], tkeep=64'h0000_0000_FFFF_FFFF, tlast=1.
  - in_tready=0 during the FLUSH cycle.
- 10000 random TLPs, out_tready random (deasserted 1 cycle in 16) → reassembled in-band TLPs match the input; no drops or duplicates; output stable while stalled.
- Reset asserted on beat 2 of a 3-beat TLP → out_tvalid=0 within the same cycle. The next SOP is processed correctly with the carry cleared.
- With OFS_FIM_PCIE_SS_SB2IB_LEN_CHECK_EN: header length=4 but 8 DW of keep sent → err_len=1 after the tlast accept, remaining 1 until rst.
